// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants for the dmem arbiter slice.
//   XLEN          - default data/address width
//   IDLE/ACCESS/WCHK - arbiter FSM encodings
//   EXC_*         - dmem exception codes, also used by dmem and trap logic
package dmem_arbiter_pkg;

   localparam int XLEN = 64;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WCHK   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = IDLE,
      S_ACCESS = ACCESS,
      S_WCHK   = WCHK
   } state_t;

   localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
   localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
   localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and dmem-side signals of the arbiter.
//   requester: req, we, word_sel, addr, wdata -> gnt, rsp_*
//   dmem:      we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data
//              <- dmem_data, dmem_exc_en, dmem_exc_code, dmem_exc_val
// slave = arbiter view, master = environment (requesters + dmem) view.
interface dmem_arbiter_if #(
   parameter int XLEN = dmem_arbiter_pkg::XLEN
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [15:0]       word_sel;
   logic [2*XLEN-1:0] addr;
   logic [2*XLEN-1:0] wdata;
   logic [1:0]        gnt;
   logic [1:0]        rsp_valid;
   logic [XLEN-1:0]   rsp_data;
   logic              rsp_exc_en;
   logic [3:0]        rsp_exc_code;
   logic [XLEN-1:0]   rsp_exc_val;
   logic              we_dmem;
   logic              is_LOAD;
   logic [7:0]        dmem_word_sel;
   logic [XLEN-1:0]   r_dmem_addr;
   logic [XLEN-1:0]   w_dmem_data;
   logic [XLEN-1:0]   dmem_data;
   logic              dmem_exc_en;
   logic [3:0]        dmem_exc_code;
   logic [XLEN-1:0]   dmem_exc_val;

   modport slave (
      input  req, we, word_sel, addr, wdata,
      input  dmem_data, dmem_exc_en, dmem_exc_code, dmem_exc_val,
      output gnt, rsp_valid, rsp_data, rsp_exc_en, rsp_exc_code, rsp_exc_val,
      output we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data
   );

   modport master (
      output req, we, word_sel, addr, wdata,
      output dmem_data, dmem_exc_en, dmem_exc_code, dmem_exc_val,
      input  gnt, rsp_valid, rsp_data, rsp_exc_en, rsp_exc_code, rsp_exc_val,
      input  we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way picker.
//   req[1:0] - requests
//   last     - port granted most recently (1 = port 1)
//   mode     - 0 = round-robin, 1 = port 0 always wins a tie
//   gnt[1:0] - one-hot winner, 0 when nobody requests
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       mode,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (mode || last) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one dmem between port 0 (LSU) and port 1 (debug/DMA).
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - requester handshake, response and dmem pins (slave modport)
// One transaction in flight; load response 2 cycles after gnt, store 3.
//
// state  | meaning
// IDLE   | arbitrate, latch winner fields on gnt
// ACCESS | dmem pins driven from latched fields; loads respond here
// WCHK   | store committed, collect dmem fault status and respond
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int XLEN      = dmem_arbiter_pkg::XLEN,
   parameter bit PRIO_MODE = 1'b0
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   state_t            state, state_nxt;
   logic [1:0]        arb_gnt;
   logic              win;
   logic              last_grant;
   logic              owner;
   logic              lat_we;
   logic [7:0]        lat_sel;
   logic [XLEN-1:0]   lat_addr;
   logic [XLEN-1:0]   lat_wdata;
   logic [1:0]        rsp_valid_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic              rsp_exc_en_q;
   logic [3:0]        rsp_exc_code_q;
   logic [XLEN-1:0]   rsp_exc_val_q;

   rr_arb2 u_arb (
      .req  (bus.req),
      .last (last_grant),
      .mode (PRIO_MODE),
      .gnt  (arb_gnt)
   );

   assign win = arb_gnt[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // dmem pins decode straight from state so reset kills we_dmem immediately.
   always_comb begin
      state_nxt         = state;
      bus.gnt           = 2'b00;
      bus.we_dmem       = 1'b0;
      bus.is_LOAD       = 1'b0;
      bus.dmem_word_sel = '0;
      bus.r_dmem_addr   = '0;
      bus.w_dmem_data   = '0;
      case (state)
         S_IDLE: begin
            bus.gnt = arb_gnt;
            if (|arb_gnt) state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            bus.we_dmem       = lat_we;
            bus.is_LOAD       = !lat_we;
            bus.dmem_word_sel = lat_sel;
            bus.r_dmem_addr   = lat_addr;
            bus.w_dmem_data   = lat_wdata;
            state_nxt         = lat_we ? S_WCHK : S_IDLE;
         end
         S_WCHK:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         lat_we         <= 1'b0;
         lat_sel        <= '0;
         lat_addr       <= '0;
         lat_wdata      <= '0;
         rsp_valid_q    <= 2'b00;
         rsp_data_q     <= '0;
         rsp_exc_en_q   <= 1'b0;
         rsp_exc_code_q <= '0;
         rsp_exc_val_q  <= '0;
      end else begin
         rsp_valid_q <= 2'b00;
         case (state)
            S_IDLE: begin
               if (|arb_gnt) begin
                  owner      <= win;
                  last_grant <= win;
                  lat_we     <= bus.we[win];
                  lat_sel    <= bus.word_sel[8*win +: 8];
                  lat_addr   <= bus.addr[XLEN*win +: XLEN];
                  lat_wdata  <= bus.wdata[XLEN*win +: XLEN];
               end
            end
            S_ACCESS: begin
               if (!lat_we) begin
                  rsp_data_q     <= bus.dmem_exc_en ? '0 : bus.dmem_data;
                  rsp_exc_en_q   <= bus.dmem_exc_en;
                  rsp_exc_code_q <= bus.dmem_exc_code;
                  rsp_exc_val_q  <= bus.dmem_exc_val;
                  rsp_valid_q    <= owner ? 2'b10 : 2'b01;
               end
            end
            S_WCHK: begin
               rsp_data_q     <= '0;
               rsp_exc_en_q   <= bus.dmem_exc_en;
               rsp_exc_code_q <= bus.dmem_exc_code;
               rsp_exc_val_q  <= bus.dmem_exc_val;
               rsp_valid_q    <= owner ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_exc_en   = rsp_exc_en_q;
   assign bus.rsp_exc_code = rsp_exc_code_q;
   assign bus.rsp_exc_val  = rsp_exc_val_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small dmem model.
// dut_rr runs round-robin against the memory model; dut_fp runs fixed
// priority with dmem inputs tied off and is only used for grant order.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.XLEN(64)) bus ();
   dmem_arbiter_if #(.XLEN(64)) bus_fp ();

   dmem_arbiter #(.XLEN(64), .PRIO_MODE(1'b0)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   dmem_arbiter #(.XLEN(64), .PRIO_MODE(1'b1)) dut_fp (
      .clk (clk),
      .rst (rst),
      .bus (bus_fp)
   );

   // dmem model: 128 doublewords, fault at/above 0x400, misaligned if addr[2:0] != 0.
   // Loads report status combinationally; store status is registered at the commit edge.
   logic [63:0] mem [0:127];
   logic        st_exc_en   = 1'b0;
   logic [3:0]  st_exc_code = 4'd0;
   logic [63:0] st_exc_val  = 64'd0;
   logic        m_mis, m_flt;
   logic [6:0]  m_idx;

   assign m_mis = (bus.r_dmem_addr[2:0] != 3'd0);
   assign m_flt = (bus.r_dmem_addr >= 64'h400);
   assign m_idx = bus.r_dmem_addr[9:3];

   always @(posedge clk) begin
      if (bus.we_dmem) begin
         st_exc_en   <= m_mis | m_flt;
         st_exc_code <= m_mis ? EXC_ST_MISALIGN : EXC_ST_FAULT;
         st_exc_val  <= bus.r_dmem_addr;
         if (!m_mis && !m_flt) begin
            for (int b = 0; b < 8; b++)
               if (bus.dmem_word_sel[b]) mem[m_idx][8*b +: 8] <= bus.w_dmem_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      bus.dmem_data     = 64'd0;
      bus.dmem_exc_en   = st_exc_en;
      bus.dmem_exc_code = st_exc_code;
      bus.dmem_exc_val  = st_exc_val;
      if (bus.is_LOAD) begin
         bus.dmem_data     = mem[m_idx];
         bus.dmem_exc_en   = m_mis | m_flt;
         bus.dmem_exc_code = m_mis ? EXC_LD_MISALIGN : EXC_LD_FAULT;
         bus.dmem_exc_val  = bus.r_dmem_addr;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1 with the DUT in IDLE; req is dropped the cycle after gnt.
   task automatic run_txn(input string tag, input int p, input logic w, input logic [7:0] sel,
                          input logic [63:0] a, input logic [63:0] d, input logic exp_exc,
                          input logic [3:0] exp_code, input logic [63:0] exp_data);
      logic [1:0] m;
      m = (p == 0) ? 2'b01 : 2'b10;
      bus.req                = m;
      bus.we[p]              = w;
      bus.word_sel[8*p +: 8] = sel;
      bus.addr[64*p +: 64]   = a;
      bus.wdata[64*p +: 64]  = d;
      #1 chk({tag, "_gnt"}, 64'(bus.gnt), 64'(m));
      @(posedge clk); #1;
      bus.req = 2'b00;
      chk({tag, "_acc_gnt"}, 64'(bus.gnt), 64'd0);
      chk({tag, "_acc_we"}, 64'(bus.we_dmem), 64'(w));
      chk({tag, "_acc_ld"}, 64'(bus.is_LOAD), 64'(!w));
      chk({tag, "_acc_addr"}, bus.r_dmem_addr, a);
      if (w) begin
         @(posedge clk); #1;
         chk({tag, "_wchk_we"}, 64'(bus.we_dmem), 64'd0);
         chk({tag, "_wchk_rsp"}, 64'(bus.rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      chk({tag, "_rsp"}, 64'(bus.rsp_valid), 64'(m));
      chk({tag, "_exc"}, 64'(bus.rsp_exc_en), 64'(exp_exc));
      chk({tag, "_data"}, bus.rsp_data, exp_data);
      if (exp_exc) begin
         chk({tag, "_code"}, 64'(bus.rsp_exc_code), 64'(exp_code));
         chk({tag, "_val"}, bus.rsp_exc_val, a);
      end
      chk({tag, "_nogrant"}, 64'(bus.gnt), 64'd0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_hold"}, bus.rsp_data, exp_data);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 64'd0;
      bus.req = '0;  bus.we = '0;  bus.word_sel = '0;  bus.addr = '0;  bus.wdata = '0;
      bus_fp.req = '0;  bus_fp.we = '0;  bus_fp.word_sel = '0;
      bus_fp.addr = '0;  bus_fp.wdata = '0;
      bus_fp.dmem_data = '0;  bus_fp.dmem_exc_en = 1'b0;
      bus_fp.dmem_exc_code = '0;  bus_fp.dmem_exc_val = '0;

      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_gnt", 64'(bus.gnt), 64'd0);
      chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("rst_we", 64'(bus.we_dmem), 64'd0);
      chk("rst_ld", 64'(bus.is_LOAD), 64'd0);
      chk("rst_addr", bus.r_dmem_addr, 64'd0);
      chk("rst_data", bus.rsp_data, 64'd0);
      chk("rst_fp_gnt", 64'(bus_fp.gnt), 64'd0);

      run_txn("st10", 0, 1'b1, 8'hFF, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, 4'd0, 64'd0);
      run_txn("ld10", 0, 1'b0, 8'hFF, 64'h10, 64'd0, 1'b0, 4'd0, 64'hDEADBEEF_CAFEF00D);
      run_txn("ld12", 1, 1'b0, 8'h0F, 64'h12, 64'd0, 1'b1, 4'd4, 64'd0);
      run_txn("st400", 0, 1'b1, 8'hFF, 64'h400, 64'h1234_5678_9ABC_DEF0, 1'b1, 4'd7, 64'd0);
      run_txn("ld00", 0, 1'b0, 8'hFF, 64'h0, 64'd0, 1'b0, 4'd0, 64'd0);

      // Reset while a store to 0x20 sits in ACCESS.
      bus.req = 2'b01;  bus.we[0] = 1'b1;  bus.word_sel[7:0] = 8'hFF;
      bus.addr[63:0] = 64'h20;  bus.wdata[63:0] = 64'h5555_AAAA_5555_AAAA;
      #1 chk("rstmid_gnt", 64'(bus.gnt), 64'd1);
      @(posedge clk); #1;
      bus.req = 2'b00;
      chk("rstmid_acc_we", 64'(bus.we_dmem), 64'd1);
      #2 rst = 1'b0;
      #1 chk("rstmid_we_drop", 64'(bus.we_dmem), 64'd0);
      chk("rstmid_rsp0", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk("rstmid_rsp1", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_rsp2", 64'(bus.rsp_valid), 64'd0);
      chk("rstmid_idle_we", 64'(bus.we_dmem), 64'd0);

      // Both ports stream loads: port 0 from 0x10, port 1 from 0x08.
      bus.we = 2'b00;  bus.word_sel = 16'hFFFF;
      bus.addr = {64'h08, 64'h10};
      bus.req = 2'b11;
      bus_fp.req = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_gnt%0d", k), 64'(bus.gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
         chk($sformatf("fp_gnt%0d", k), 64'(bus_fp.gnt), 64'd1);
         if (k > 0) begin
            chk($sformatf("rr_rsp%0d", k), 64'(bus.rsp_valid), (k % 2 == 1) ? 64'd1 : 64'd2);
            chk($sformatf("rr_data%0d", k), bus.rsp_data,
                (k % 2 == 1) ? 64'hDEADBEEF_CAFEF00D : 64'd0);
            chk($sformatf("fp_rsp%0d", k), 64'(bus_fp.rsp_valid), 64'd1);
         end
         @(posedge clk); #1;
         if (k == 3) begin
            bus.req = 2'b00;
            bus_fp.req = 2'b00;
         end
         chk($sformatf("rr_acc_gnt%0d", k), 64'(bus.gnt), 64'd0);
         @(posedge clk); #1;
      end
      chk("rr_rsp_last", 64'(bus.rsp_valid), 64'd2);
      chk("rr_data_last", bus.rsp_data, 64'd0);
      chk("rr_idle_gnt", 64'(bus.gnt), 64'd0);
      chk("fp_rsp_last", 64'(bus_fp.rsp_valid), 64'd1);

      run_txn("ld20", 0, 1'b0, 8'hFF, 64'h20, 64'd0, 1'b0, 4'd0, 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port request/response arbiter sharing the single data memory (dmem) between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Accepts one transaction at a time, drives the dmem control/address/data pins from latched fields, and returns load data or the fault status to the owning port as a one-cycle response pulse.
- Sits between the LSU/debug logic and dmem; dmem itself is unchanged.

Parameters:
- XLEN, 64, data/address width.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with port 0 always winning.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; bit i belongs to port i.
- we  in  2  per-port store (1) / load (0).
- word_sel  in  16  per-port byte-lane select; [8i+7:8i] belongs to port i.
- addr  in  2*XLEN  per-port byte address; slice i.
- wdata  in  2*XLEN  per-port store data; slice i.
- gnt  out  2  one-hot acceptance pulse.
- rsp_valid  out  2  one-hot response pulse; identifies the owning port.
- rsp_data  out  XLEN  load data; 0 for stores and faults.
- rsp_exc_en  out  1  fault flag for the response.
- rsp_exc_code  out  4  4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault.
- rsp_exc_val  out  XLEN  faulting address.
- we_dmem  out  1  to dmem.
- is_LOAD  out  1  to dmem.
- dmem_word_sel  out  8  to dmem.
- r_dmem_addr  out  XLEN  to dmem.
- w_dmem_data  out  XLEN  to dmem.
- dmem_data  in  XLEN  from dmem, combinational read.
- dmem_exc_en  in  1  from dmem.
- dmem_exc_code  in  4  from dmem.
- dmem_exc_val  in  XLEN  from dmem.

Behaviour:
- FSM states: IDLE, ACCESS, WCHK.
- Reset (rst = 0, async): state = IDLE, last_grant = 1 (so port 0 wins first), all latched fields = 0, all registered outputs = 0.
- IDLE:
  - Arbitration is combinational on req.
  - PRIO_MODE = 0: the port other than last_grant wins when both request.
  - PRIO_MODE = 1: port 0 always wins.
  - gnt[winner] = 1 in this cycle.
  - At the clock edge: latch we/word_sel/addr/wdata of the winner plus the owner id, update last_grant, go to ACCESS.
  - Requester may drop req or change its fields from the next cycle on.
- ACCESS (one cycle):
  - we_dmem = latched we; is_LOAD = !latched we; other dmem pins driven from latched fields.
  - Load: at the edge, capture dmem_data, dmem_exc_en, dmem_exc_code and dmem_exc_val into the rsp registers; pulse rsp_valid[owner] next cycle; go to IDLE. If exc_en is captured, rsp_data = 0.
  - Store: dmem commits at this edge; go to WCHK.
- WCHK (store only):
  - we_dmem = 0, is_LOAD = 0.
  - At the edge, capture the dmem exc signals, set rsp_data = 0, pulse rsp_valid[owner]; go to IDLE.
- Outside ACCESS: we_dmem = is_LOAD = 0; dmem_word_sel, r_dmem_addr and w_dmem_data = 0.
- Latency from gnt cycle (cycle 0) to rsp_valid: load = cycle 2, store = cycle 3.
- Throughput: next gnt no earlier than the rsp_valid cycle, i.e. one transaction per 2 cycles (load) or 3 cycles (store).
- rsp_valid and all rsp_* are registered.
  - rsp_valid is a single-cycle pulse.
  - rsp_data/rsp_exc_* hold their value until the next response.
- Simultaneous req in IDLE: exactly one gnt bit set; the loser keeps req high and wins the next IDLE arbitration (round-robin mode).
- req deasserted while the port is still pending: ignored; the transaction completes normally.
- Reset mid-transaction:
  - Immediate return to IDLE with no rsp_valid.
  - we_dmem drops asynchronously, so a store in ACCESS whose edge has not occurred is not written.
- No req in IDLE: no gnt; dmem pins stay idle.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE = 2'd0, ACCESS = 2'd1, WCHK = 2'd2);
  - exception code constants (EXC_LD_MISALIGN = 4, EXC_LD_FAULT = 5, EXC_ST_MISALIGN = 6, EXC_ST_FAULT = 7), reused by dmem and trap logic;
  - XLEN.
- One sub-module: rr_arb2, a 2-way round-robin/fixed-priority picker with inputs req[1:0], last, mode and output gnt[1:0]. Purely combinational; last_grant lives in dmem_arbiter.

Test Plan:
- Port 0 store, word_sel = 8'hFF, addr = 0x10, wdata = 0xDEADBEEF_CAFEF00D, then port 0 load of addr 0x10 → store rsp_valid = 2'b01 at cycle 3 with exc_en = 0; load rsp_valid at cycle 2 with rsp_data = 0xDEADBEEF_CAFEF00D.
- Both ports request loads every cycle (PRIO_MODE = 0) → gnt sequence 01, 10, 01, 10; each rsp_valid bit matches its preceding gnt; PRIO_MODE = 1 → gnt = 01 only.
- Port 1 load, word_sel = 8'h0F, addr = 0x12 → rsp_exc_en = 1, code = 4, exc_val = 0x12, rsp_data = 0.
- Port 0 store to addr 0x400 → rsp at cycle 3 with code = 7, exc_val = 0x400; a later load of 0x0 returns unchanged memory contents.
- rst pulsed low during ACCESS of a store to 0x20 → no rsp_valid; a following load of 0x20 returns the old value (0); state returns to IDLE and port 0 wins the next arbitration.
- Port 0 drops req the cycle after gnt → response is still delivered at the normal latency; no second gnt for port 0.
